// File: rtl/frm_zone_classifier.sv
// Per-frame, per-zone dark/light classifier with percentage hysteresis and debounce.
// Each active line is split into ZONES equal horizontal zones. Bright and total pixel
// counts are accumulated per zone over a frame. On each vs falling edge every zone is
// re-judged, and the invert mask plus a global majority flag are updated.
module frm_zone_classifier #(
  parameter int unsigned ZONES    = 4,
  parameter int unsigned H_ACTIVE = 1920,
  parameter int unsigned WD_W     = 8,
  parameter int unsigned LUMA_THR = 128,
  parameter int unsigned CNT_W    = 22,
  parameter int unsigned HI_NUM   = 9,
  parameter int unsigned LO_NUM   = 7,
  parameter int unsigned DEBOUNCE = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             vs_i,
  input  logic             de_i,
  input  logic [WD_W-1:0]  wd_i,
  output logic [ZONES-1:0] zone_o,
  output logic             rx_o,
  output logic             frm_done_o
);

  localparam int unsigned ZPIX   = H_ACTIVE / ZONES;
  localparam int unsigned COL_W  = $clog2(ZPIX + 1);
  localparam int unsigned ZIDX_W = (ZONES > 1) ? $clog2(ZONES) : 1;
  localparam int unsigned DEB_W  = $clog2(DEBOUNCE + 1);
  // Wide enough for brt*16 and tot*16 without truncation.
  localparam int unsigned CMP_W  = CNT_W + 5;

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [ZIDX_W-1:0] ZIDX_TOP = ZIDX_W'(ZONES - 1);
  localparam logic [COL_W-1:0]  COL_TOP  = COL_W'(ZPIX - 1);

  logic                vs_r_q;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ZIDX_W-1:0]   zidx_q, zidx_d;
  logic [CNT_W-1:0]    tot_q [ZONES];
  logic [CNT_W-1:0]    tot_d [ZONES];
  logic [CNT_W-1:0]    brt_q [ZONES];
  logic [CNT_W-1:0]    brt_d [ZONES];
  logic [DEB_W-1:0]    deb_q [ZONES];
  logic [DEB_W-1:0]    deb_d [ZONES];
  logic [ZONES-1:0]    inv_q, inv_d;
  logic                rx_q, rx_d;
  logic                frm_done_q, frm_done_d;

  logic                ev;
  logic                bright;
  logic [ZONES-1:0]    want;
  logic [CMP_W-1:0]    brt16  [ZONES];
  logic [CMP_W-1:0]    tot_hi [ZONES];
  logic [CMP_W-1:0]    tot_lo [ZONES];

  assign ev     = vs_r_q & ~vs_i;
  assign bright = (wd_i >= WD_W'(LUMA_THR));

  // Column position within the current zone and zone index; last zone absorbs overflow.
  always_comb begin
    col_d  = col_q;
    zidx_d = zidx_q;
    if (!de_i) begin
      col_d  = '0;
      zidx_d = '0;
    end else if (zidx_q != ZIDX_TOP) begin
      if (col_q == COL_TOP) begin
        col_d  = '0;
        zidx_d = zidx_q + ZIDX_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // Saturating per-zone accumulators; on a frame event they restart from this pixel.
  always_comb begin
    for (int z = 0; z < ZONES; z++) begin
      tot_d[z] = tot_q[z];
      brt_d[z] = brt_q[z];
      if (ev) begin
        tot_d[z] = CNT_W'(de_i && (zidx_q == ZIDX_W'(z)));
        brt_d[z] = CNT_W'(de_i && (zidx_q == ZIDX_W'(z)) && bright);
      end else if (de_i && (zidx_q == ZIDX_W'(z))) begin
        if (tot_q[z] != CNT_MAX) tot_d[z] = tot_q[z] + CNT_W'(1);
        if (bright && (brt_q[z] != CNT_MAX)) brt_d[z] = brt_q[z] + CNT_W'(1);
      end
    end
  end

  // Hysteresis verdict per zone from the pre-event accumulator values.
  always_comb begin
    for (int z = 0; z < ZONES; z++) begin
      brt16[z]  = CMP_W'(brt_q[z]) << 4;
      tot_hi[z] = CMP_W'(tot_q[z]) * CMP_W'(HI_NUM);
      tot_lo[z] = CMP_W'(tot_q[z]) * CMP_W'(LO_NUM);
      if (tot_q[z] == '0) begin
        want[z] = inv_q[z];
      end else if (inv_q[z]) begin
        want[z] = (brt16[z] >= tot_lo[z]);
      end else begin
        want[z] = (brt16[z] >= tot_hi[z]);
      end
    end
  end

  // Debounce: a zone flips only after DEBOUNCE consecutive disagreeing frames.
  always_comb begin
    inv_d = inv_q;
    for (int z = 0; z < ZONES; z++) begin
      deb_d[z] = deb_q[z];
      if (ev) begin
        if ((tot_q[z] == '0) || (want[z] == inv_q[z])) begin
          deb_d[z] = '0;
        end else if (deb_q[z] + DEB_W'(1) == DEB_W'(DEBOUNCE)) begin
          inv_d[z] = ~inv_q[z];
          deb_d[z] = '0;
        end else begin
          deb_d[z] = deb_q[z] + DEB_W'(1);
        end
      end
    end
  end

  // Majority flag and completion pulse, both tied to the frame event.
  always_comb begin
    rx_d       = rx_q;
    frm_done_d = ev;
    if (ev) rx_d = ($countones(inv_d) >= int'((ZONES + 1) / 2));
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vs_r_q     <= 1'b0;
      col_q      <= '0;
      zidx_q     <= '0;
      tot_q      <= '{default: '0};
      brt_q      <= '{default: '0};
      deb_q      <= '{default: '0};
      inv_q      <= '0;
      rx_q       <= 1'b0;
      frm_done_q <= 1'b0;
    end else begin
      vs_r_q     <= vs_i;
      col_q      <= col_d;
      zidx_q     <= zidx_d;
      tot_q      <= tot_d;
      brt_q      <= brt_d;
      deb_q      <= deb_d;
      inv_q      <= inv_d;
      rx_q       <= rx_d;
      frm_done_q <= frm_done_d;
    end
  end

  assign zone_o     = inv_q;
  assign rx_o       = rx_q;
  assign frm_done_o = frm_done_q;

endmodule

// File: tb/tb_frm_zone_classifier.sv
// Bench for frm_zone_classifier: three instances (debounce 1, debounce 3, 4-bit counters)
// share one stimulus stream; a frame-level model queues the expected mask per event.
module tb_frm_zone_classifier;

  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       vs_i = 1'b0;
  logic       de_i = 1'b0;
  logic [7:0] wd_i = 8'd0;

  logic [3:0] zone_w [NI];
  logic       rx_w   [NI];
  logic       done_w [NI];

  int n_vec = 0;
  int n_bad = 0;

  // Model state per instance.
  longint     m_tot [NI][4];
  longint     m_brt [NI][4];
  int         m_deb [NI][4];
  logic       m_inv [NI][4];
  longint     lim   [NI] = '{(64'd1 << 22) - 1, (64'd1 << 22) - 1, 64'd15};
  int         dbn   [NI] = '{1, 3, 1};
  logic [4:0] exp_q [NI][$];
  logic [4:0] e;

  always #5 clk = ~clk;

  frm_zone_classifier #(.ZONES(4), .H_ACTIVE(16), .CNT_W(22), .DEBOUNCE(1)) u_d1 (
    .clk_i(clk), .rst_i(rst_i), .vs_i(vs_i), .de_i(de_i), .wd_i(wd_i),
    .zone_o(zone_w[0]), .rx_o(rx_w[0]), .frm_done_o(done_w[0])
  );
  frm_zone_classifier #(.ZONES(4), .H_ACTIVE(16), .CNT_W(22), .DEBOUNCE(3)) u_d3 (
    .clk_i(clk), .rst_i(rst_i), .vs_i(vs_i), .de_i(de_i), .wd_i(wd_i),
    .zone_o(zone_w[1]), .rx_o(rx_w[1]), .frm_done_o(done_w[1])
  );
  frm_zone_classifier #(.ZONES(4), .H_ACTIVE(16), .CNT_W(4), .DEBOUNCE(1)) u_sat (
    .clk_i(clk), .rst_i(rst_i), .vs_i(vs_i), .de_i(de_i), .wd_i(wd_i),
    .zone_o(zone_w[2]), .rx_o(rx_w[2]), .frm_done_o(done_w[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      for (int z = 0; z < 4; z++) begin
        m_tot[i][z] = 0;
        m_brt[i][z] = 0;
        m_deb[i][z] = 0;
        m_inv[i][z] = 1'b0;
      end
      exp_q[i].delete();
    end
  endtask

  task automatic model_pix(input int z, input bit b);
    for (int i = 0; i < NI; i++) begin
      if (m_tot[i][z] < lim[i]) m_tot[i][z]++;
      if (b && (m_brt[i][z] < lim[i])) m_brt[i][z]++;
    end
  endtask

  task automatic model_event();
    logic [3:0] zv;
    int         pop;
    logic       w;
    for (int i = 0; i < NI; i++) begin
      pop = 0;
      for (int z = 0; z < 4; z++) begin
        if (m_tot[i][z] == 0) begin
          m_deb[i][z] = 0;
        end else begin
          if (m_inv[i][z]) w = (m_brt[i][z] * 16 >= m_tot[i][z] * 7);
          else             w = (m_brt[i][z] * 16 >= m_tot[i][z] * 9);
          if (w == m_inv[i][z]) m_deb[i][z] = 0;
          else if (m_deb[i][z] + 1 == dbn[i]) begin
            m_inv[i][z] = w;
            m_deb[i][z] = 0;
          end else m_deb[i][z]++;
        end
        zv[z] = m_inv[i][z];
        pop += int'(m_inv[i][z]);
        m_tot[i][z] = 0;
        m_brt[i][z] = 0;
      end
      exp_q[i].push_back({pop >= 2, zv});
    end
  endtask

  task automatic cyc(input logic vs, input logic de, input logic [7:0] wd);
    @(posedge clk);
    #1;
    vs_i = vs;
    de_i = de;
    wd_i = wd;
  endtask

  // One line: zone z has its first nb[z] pixels bright; extra bright pixels past H_ACTIVE.
  task automatic line(input int nb0, input int nb1, input int nb2, input int nb3,
                      input int extra);
    int  nb [4];
    bit  b;
    nb = '{nb0, nb1, nb2, nb3};
    for (int j = 0; j < 16; j++) begin
      b = ((j % 4) < nb[j / 4]);
      cyc(1'b0, 1'b1, b ? 8'd200 : 8'd10);
      model_pix(j / 4, b);
    end
    for (int j = 0; j < extra; j++) begin
      cyc(1'b0, 1'b1, 8'd200);
      model_pix(3, 1'b1);
    end
    cyc(1'b0, 1'b0, 8'd0);
    cyc(1'b0, 1'b0, 8'd0);
  endtask

  task automatic vs_pulse();
    cyc(1'b1, 1'b0, 8'd0);
    cyc(1'b0, 1'b0, 8'd0);
    model_event();
    cyc(1'b0, 1'b0, 8'd0);
    cyc(1'b0, 1'b0, 8'd0);
    cyc(1'b0, 1'b0, 8'd0);
  endtask

  task automatic frame(input int nl, input int nb0, input int nb1, input int nb2, input int nb3);
    for (int l = 0; l < nl; l++) line(nb0, nb1, nb2, nb3, 0);
    vs_pulse();
  endtask

  // Scoreboard: every completion pulse pops one expected mask per instance.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (done_w[i] === 1'b1) begin
        if (exp_q[i].size() == 0) begin
          check($sformatf("unexpected_done[%0d]", i), 32'(done_w[i]), 32'd0);
        end else begin
          e = exp_q[i].pop_front();
          check($sformatf("zone[%0d]", i), 32'(zone_w[i]), 32'(e[3:0]));
          check($sformatf("rx[%0d]", i), 32'(rx_w[i]), 32'(e[4]));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_zone[%0d]", i), 32'(zone_w[i]), 32'd0);
      check($sformatf("rst_rx[%0d]", i), 32'(rx_w[i]), 32'd0);
      check($sformatf("rst_done[%0d]", i), 32'(done_w[i]), 32'd0);
    end
    rst_i = 1'b0;

    // Basic split: zones 0-1 bright, 2-3 dark.
    frame(2, 4, 4, 0, 0);
    check("basic_zone", 32'(zone_w[0]), 32'h3);
    check("basic_rx", 32'(rx_w[0]), 32'd1);

    // Hysteresis on zone 0 (debounce 1).
    frame(4, 0, 0, 0, 0);
    frame(4, 2, 0, 0, 0);
    check("hyst_8of16", 32'(zone_w[0][0]), 32'd0);
    line(3, 0, 0, 0, 0); line(2, 0, 0, 0, 0); line(2, 0, 0, 0, 0); line(2, 0, 0, 0, 0);
    vs_pulse();
    check("hyst_9of16", 32'(zone_w[0][0]), 32'd1);
    line(2, 0, 0, 0, 0); line(2, 0, 0, 0, 0); line(2, 0, 0, 0, 0); line(1, 0, 0, 0, 0);
    vs_pulse();
    check("hyst_7of16", 32'(zone_w[0][0]), 32'd1);
    line(2, 0, 0, 0, 0); line(2, 0, 0, 0, 0); line(1, 0, 0, 0, 0); line(1, 0, 0, 0, 0);
    vs_pulse();
    check("hyst_6of16", 32'(zone_w[0][0]), 32'd0);

    // Debounce 3: bright, bright, dark restarts, then three bright flips.
    frame(4, 4, 0, 0, 0);
    check("deb_b1", 32'(zone_w[1][0]), 32'd0);
    frame(4, 4, 0, 0, 0);
    check("deb_b2", 32'(zone_w[1][0]), 32'd0);
    frame(4, 0, 0, 0, 0);
    frame(4, 4, 0, 0, 0);
    frame(4, 4, 0, 0, 0);
    check("deb_restart", 32'(zone_w[1][0]), 32'd0);
    frame(4, 4, 0, 0, 0);
    check("deb_b3", 32'(zone_w[1][0]), 32'd1);

    // Empty frame holds the mask and clears pending debounce.
    frame(2, 4, 4, 4, 4);
    frame(2, 4, 4, 4, 4);
    check("all_bright", 32'(zone_w[0]), 32'hF);
    vs_pulse();
    check("empty_hold", 32'(zone_w[0]), 32'hF);
    frame(2, 4, 4, 4, 4);
    check("empty_deb_clr", 32'(zone_w[1]), 32'h1);

    // Saturation: 16 bright then 24 dark pixels in zone 0 with 4-bit counters.
    frame(4, 0, 0, 0, 0);
    for (int l = 0; l < 4; l++) line(4, 0, 0, 0, 0);
    for (int l = 0; l < 6; l++) line(0, 0, 0, 0, 0);
    vs_pulse();
    check("sat_zone", 32'(zone_w[2]), 32'h1);
    check("sat_wide", 32'(zone_w[0]), 32'h0);

    // Pixels past H_ACTIVE land in the last zone.
    line(0, 0, 0, 0, 12);
    line(0, 0, 0, 0, 12);
    vs_pulse();
    check("overflow_zone", 32'(zone_w[0]), 32'h8);
    check("overflow_rx", 32'(rx_w[0]), 32'd0);

    // Back-to-back events with vs toggling every cycle.
    cyc(1'b1, 1'b0, 8'd0);
    cyc(1'b0, 1'b0, 8'd0);
    model_event();
    cyc(1'b1, 1'b0, 8'd0);
    cyc(1'b0, 1'b0, 8'd0);
    model_event();
    repeat (3) cyc(1'b0, 1'b0, 8'd0);

    // Reset mid-line with vs held high across reset.
    frame(2, 4, 0, 4, 0);
    check("pre_rst_zone", 32'(zone_w[0]), 32'h5);
    check("pre_rst_rx", 32'(rx_w[0]), 32'd1);
    for (int j = 0; j < 6; j++) cyc(1'b0, 1'b1, 8'd200);
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    de_i  = 1'b0;
    vs_i  = 1'b1;
    model_reset();
    #1;
    check("async_rst_zone", 32'(zone_w[0]), 32'd0);
    check("async_rst_rx", 32'(rx_w[0]), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    vs_i  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("no_done_after_rst", 32'(done_w[0]), 32'd0);
    end

    // First post-reset frame sees only new pixels.
    frame(2, 0, 4, 0, 0);
    check("post_rst_zone", 32'(zone_w[0]), 32'h2);
    check("post_rst_rx", 32'(rx_w[0]), 32'd0);

    for (int i = 0; i < NI; i++) begin
      check($sformatf("pending[%0d]", i), 32'(exp_q[i].size()), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
